// File: rtl/or4_serial_rx_pkg.sv
// Shared types and helpers for the serial OR receiver.
// Optional parity mode: OR4_SERIAL_RX_PARITY_EN.
package or4_serial_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int MAX_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    // Even parity bit of a word (upper unused bits must be zero).
    function automatic logic even_parity(
        input logic [MAX_WIDTH-1:0] w
    );
        return ^w;
    endfunction

endpackage

// File: rtl/or4_serial_rx_if.sv
// Serial input, parallel output and flag signals of the receiver.
// Optional parity mode: OR4_SERIAL_RX_PARITY_EN (adds perr).
interface or4_serial_rx_if #(
    parameter int WIDTH = or4_serial_pkg::DEF_WIDTH
);
    logic             sin_valid;
    logic             sin_start;
    logic             sin_a;
    logic             sin_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_s;
    logic             overrun;
    logic             clr_flags;
`ifdef OR4_SERIAL_RX_PARITY_EN
    logic             perr;
`endif

    modport master (
        output sin_valid,
        output sin_start,
        output sin_a,
        output sin_b,
        output out_ready,
        output clr_flags,
`ifdef OR4_SERIAL_RX_PARITY_EN
        input  perr,
`endif
        input  out_valid,
        input  out_s,
        input  overrun
    );

    modport slave (
        input  sin_valid,
        input  sin_start,
        input  sin_a,
        input  sin_b,
        input  out_ready,
        input  clr_flags,
`ifdef OR4_SERIAL_RX_PARITY_EN
        output perr,
`endif
        output out_valid,
        output out_s,
        output overrun
    );

endinterface

// File: rtl/or4_serial_rx_lane.sv
// One serial lane: LSB-first shift register plus parity accumulator.
// Optional parity mode: OR4_SERIAL_RX_PARITY_EN.
module or4_serial_lane #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic             i_bit,
`ifdef OR4_SERIAL_RX_PARITY_EN
    output logic             o_perr,
`endif
    output logic [WIDTH-1:0] o_word_nxt
);

    logic [WIDTH-1:0] r_word;
    logic [WIDTH-1:0] w_word_nxt;

    // Next word: a start bit clears stale bits, later bits enter at the MSB
    always_comb begin
        w_word_nxt = r_word;
        if (i_load) begin
            w_word_nxt = {i_bit, {(WIDTH-1){1'b0}}};
        end else if (i_shift) begin
            w_word_nxt = {i_bit, r_word[WIDTH-1:1]};
        end
    end

    // Shift register state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_word <= '0;
        end else begin
            r_word <= w_word_nxt;
        end
    end

    assign o_word_nxt = w_word_nxt;

`ifdef OR4_SERIAL_RX_PARITY_EN
    logic r_par;

    // Running XOR of this frame's data bits
    always_ff @(posedge clk) begin
        if (rst) begin
            r_par <= 1'b0;
        end else if (i_load) begin
            r_par <= i_bit;
        end else if (i_shift) begin
            r_par <= r_par ^ i_bit;
        end
    end

    // Only meaningful while the parity bit is on i_bit
    assign o_perr = r_par ^ i_bit;
`endif

endmodule

// File: rtl/or4_serial_rx.sv
// Deserialises two lanes and presents a|b on a valid/ready register.
// Optional parity mode: OR4_SERIAL_RX_PARITY_EN.
module or4_serial_rx
    import or4_serial_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input logic           clk,
    input logic           rst,
    or4_serial_rx_if.slave bus
);

    localparam int CW = $clog2(WIDTH + 2);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             w_load;
    logic             w_shift;
    logic             w_done;
    logic             w_ok;
    logic [WIDTH-1:0] w_a_nxt;
    logic [WIDTH-1:0] w_b_nxt;
    logic [WIDTH-1:0] w_res;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_s;
    logic             r_overrun;

`ifdef OR4_SERIAL_RX_PARITY_EN
    logic w_pchk;
    logic w_a_perr;
    logic w_b_perr;
    logic w_bad;
    logic r_perr;
`endif

    // Frame FSM and bit counter state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state: a start bit restarts from any state
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_done      = 1'b0;
`ifdef OR4_SERIAL_RX_PARITY_EN
        w_pchk      = 1'b0;
`endif
        if (bus.sin_valid && bus.sin_start) begin
            w_load      = 1'b1;
            w_cnt_nxt   = CW'(1);
            w_state_nxt = SHIFT;
        end else if (bus.sin_valid) begin
            unique case (r_state)
                SHIFT: begin
                    w_shift   = 1'b1;
                    w_cnt_nxt = r_cnt + CW'(1);
                    if (r_cnt == CW'(WIDTH - 1)) begin
`ifdef OR4_SERIAL_RX_PARITY_EN
                        w_state_nxt = PARITY;
`else
                        w_done      = 1'b1;
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = '0;
`endif
                    end
                end
`ifdef OR4_SERIAL_RX_PARITY_EN
                PARITY: begin
                    w_pchk      = 1'b1;
                    w_done      = 1'b1;
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
`endif
                default: begin
                end
            endcase
        end
    end

    or4_serial_lane #(.WIDTH(WIDTH)) u_lane_a (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_load),
        .i_shift   (w_shift),
        .i_bit     (bus.sin_a),
`ifdef OR4_SERIAL_RX_PARITY_EN
        .o_perr    (w_a_perr),
`endif
        .o_word_nxt(w_a_nxt)
    );

    or4_serial_lane #(.WIDTH(WIDTH)) u_lane_b (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_load),
        .i_shift   (w_shift),
        .i_bit     (bus.sin_b),
`ifdef OR4_SERIAL_RX_PARITY_EN
        .o_perr    (w_b_perr),
`endif
        .o_word_nxt(w_b_nxt)
    );

    assign w_res = w_a_nxt | w_b_nxt;

`ifdef OR4_SERIAL_RX_PARITY_EN
    assign w_bad = w_pchk & (w_a_perr | w_b_perr);
    assign w_ok  = w_done & ~w_bad;
`else
    assign w_ok  = w_done;
`endif

    // Holding register: load when empty or drained this cycle, else overrun
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_s     <= '0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_ok && (!r_out_valid || bus.out_ready)) begin
                r_out_valid <= 1'b1;
                r_out_s     <= w_res;
            end else if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_ok && r_out_valid && !bus.out_ready) begin
                r_overrun <= 1'b1;
            end else if (bus.clr_flags) begin
                r_overrun <= 1'b0;
            end
        end
    end

`ifdef OR4_SERIAL_RX_PARITY_EN
    // Sticky parity error; a new error wins over a clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perr <= 1'b0;
        end else if (w_bad) begin
            r_perr <= 1'b1;
        end else if (bus.clr_flags) begin
            r_perr <= 1'b0;
        end
    end

    assign bus.perr = r_perr;
`endif

    assign bus.out_valid = r_out_valid;
    assign bus.out_s     = r_out_s;
    assign bus.overrun   = r_overrun;

endmodule

// File: doc/or4_serial_rx.md
Name: or4_serial_rx

Overview:
- Receiving end of a bit-serial operand link that feeds the 4-bit bitwise OR datapath.
- Two serial lanes (a, b) arrive LSB first, framed by a start strobe.
- The block deserialises both lanes and produces s = a | b as one parallel word.
- The word is presented on a valid/ready output with a one-entry holding register, and overruns are flagged.

Parameters:
- WIDTH, 4, bits per lane per frame (legal range 2..16).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- sin_valid  in  1  a serial bit pair is present this cycle.
- sin_start  in  1  qualifies sin_valid: this pair is bit 0 of a new frame.
- sin_a  in  1  lane a serial bit.
- sin_b  in  1  lane b serial bit.
- out_valid  out  1  out_s holds an unconsumed result.
- out_ready  in  1  consumer accepts out_s this cycle.
- out_s  out  WIDTH  a | b of the last completed frame.
- overrun  out  1  sticky: a completed frame was dropped because the holding register was full.
- clr_flags  in  1  clears the sticky flags (overrun, and perr when the optional feature is compiled in).

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset values: state=IDLE, bit count=0, both shift registers=0, out_valid=0, out_s=0, overrun=0.
- Reset mid-frame discards the partial frame. Reset while out_valid=1 discards the held word.
- Bits are accepted only when sin_valid=1. sin_start without sin_valid is ignored.
- State IDLE:
  - sin_valid&sin_start: shift in bit 0, cnt=1, go to SHIFT.
  - sin_valid without sin_start: ignored, stay in IDLE.
- State SHIFT:
  - sin_valid&!sin_start: shift in, cnt++.
  - sin_valid&sin_start: abort the current frame and restart with this bit as bit 0 (cnt=1). No flag is raised.
  - When cnt reaches WIDTH (the last bit is shifted in that cycle), the frame completes on the same edge and the state returns to IDLE.
  - Gaps (sin_valid=0) are allowed without limit.
- Bit order: the bit received at index i lands in result bit i (LSB first).
- Completion (frame_done):
  - Result = a_word | b_word.
  - Loaded into out_s with out_valid=1 if out_valid=0, or if out_valid&out_ready in the same cycle (simultaneous consume and load: the new word wins, out_valid stays 1).
  - Otherwise the new result is dropped, out_s is unchanged, and overrun is set to 1.
- Latency: out_valid rises on the edge that samples the last serial bit, so out_valid is visible 1 cycle after that bit is presented.
- Back-to-back frames: a start may be presented on the cycle right after the last bit of the previous frame. Full throughput is 1 frame per WIDTH cycles.
- Output handshake: out_valid&out_ready consumes the word; out_valid drops next cycle unless reloaded. out_s is stable while out_valid=1 and not consumed.
- out_s keeps its last value after consumption. It is not cleared.
- overrun is cleared by clr_flags. If clr_flags and a new overrun occur in the same cycle, set wins.

Optional Feature:
- Macro: OR4_SERIAL_RX_PARITY_EN.
- Defined:
  - Each frame carries WIDTH+1 bits per lane; the last bit is even parity of that lane's WIDTH data bits.
  - Extra state PARITY after data bit WIDTH-1; the frame completes on the parity bit.
  - On a mismatch in either lane, the result is dropped (not loaded) and the sticky output perr (1 bit, reset 0, cleared by clr_flags, set wins) is set.
  - A dropped-on-parity frame never sets overrun.
- Undefined: no perr port, no PARITY state, behaviour exactly as above.

Decomposition:
- Package or4_serial_pkg:
  - State encoding constants IDLE/SHIFT/PARITY.
  - Default WIDTH constant.
  - Function for even parity of a WIDTH-bit word.
- Natural sub-module: or4_serial_lane, a per-lane shift register plus parity accumulator, instantiated twice. The FSM, counter and output register stay in the top.

Test Plan:
- Reset, then a frame a=1010b, b=0101b sent LSB first (a bits 0,1,0,1; b bits 1,0,1,0), out_ready=1 -> out_s=1111b with out_valid high for exactly 1 cycle, 1 cycle after the 4th bit.
- Frame a=0011b, b=0100b with sin_valid gaps of 3 cycles between bits -> out_s=0111b; no change while the frame is partial.
- out_ready=0, two back-to-back frames (1000b|0000b, then 0001b|0001b) -> out_s stays 1000b and overrun=1. clr_flags -> overrun=0. out_ready=1 -> 1000b consumed.
- Start re-asserted after 2 bits of a frame, followed by a full frame a=0110b, b=0000b -> a single output of 0110b; the aborted bits leave no trace.
- rst asserted after 3 bits, then a full frame a=1100b, b=0001b -> only 1101b is produced. The held word from before rst is gone: out_valid=0 right after rst.
- With OR4_SERIAL_RX_PARITY_EN: a=0111b with wrong parity bit 0 -> no output and perr=1. The same frame with parity bit 1 (b=0000b, parity 0) -> out_s=0111b.
